// File: rtl/pgm_ddram_pkg.sv
// Shared types for the PGM ddram responder.
//   state_t   : responder FSM states
//   wentry_t  : one buffered loader write {addr, be, din}
//   BURST_ONE : fixed Avalon burst count (single-beat transfers only)
// Build option: PGM_DDRAM_RDCACHE_EN (see pgm_ddram_responder.sv).
package pgm_ddram_pkg;

    localparam int          PGM_ADDR_W = 29;
    localparam logic [7:0]  BURST_ONE  = 8'd1;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        RD_DONE
    } state_t;

    typedef struct packed {
        logic [PGM_ADDR_W-1:0] addr;
        logic [7:0]            be;
        logic [63:0]           din;
    } wentry_t;

endpackage

// File: rtl/pgm_ddram_wfifo.sv
// Write buffer for loader beats headed to DDR3.
// Synchronous FIFO, show-ahead head output (head is valid whenever !empty).
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate count.
//   fixed_50m_clk  in   clock
//   reset_n        in   async active-low reset (pointers only)
//   push/push_data in   write one entry (ignored while full)
//   pop            in   drop the head entry (ignored while empty)
//   full/empty     out  occupancy flags
//   head           out  oldest entry
module pgm_ddram_wfifo
    import pgm_ddram_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    fixed_50m_clk,
    input  logic    reset_n,
    input  logic    push,
    input  wentry_t push_data,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wentry_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wentry_t     storage [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = storage[rd_ptr[AW-1:0]];

    always_ff @(posedge fixed_50m_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Data array needs no reset: entries are only read once written.
    always_ff @(posedge fixed_50m_clk) begin
        if (push && !full)
            storage[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pgm_ddram_responder.sv
// Responder end of the PGM ddram_rd/ddram_we bus, bridging to the MiSTer
// DDR3 Avalon port. Loader writes are buffered in pgm_ddram_wfifo and drained
// ahead of any read, so a read always observes earlier writes. One DDR command
// is outstanding at a time; read data comes back with a one-cycle
// ddram_dout_ready pulse and ddram_dout holds afterwards.
// Ports:
//   fixed_50m_clk, reset_n             clock, async active-low reset
//   ddram_rd/we/addr/din/be            request side inputs
//   ddram_dout/dout_ready/busy         request side outputs (registered)
//   mem_addr/burstcnt/rd/we/din/be     DDR3 command outputs (registered)
//   mem_busy/dout/dout_ready           DDR3 waitrequest / readdata / readdatavalid
// Build option PGM_DDRAM_RDCACHE_EN: single-entry read buffer; a repeated
// read of the last DDR-read address completes without a DDR access.
module pgm_ddram_responder
    import pgm_ddram_pkg::*;
#(
    parameter int WFIFO_DEPTH = 8,
    parameter int ADDR_W      = PGM_ADDR_W
) (
    input  logic              fixed_50m_clk,
    input  logic              reset_n,
    input  logic              ddram_rd,
    input  logic              ddram_we,
    input  logic [ADDR_W-1:0] ddram_addr,
    input  logic [63:0]       ddram_din,
    input  logic [7:0]        ddram_be,
    output logic [63:0]       ddram_dout,
    output logic              ddram_dout_ready,
    output logic              ddram_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_burstcnt,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [63:0]       mem_din,
    output logic [7:0]        mem_be,
    input  logic              mem_busy,
    input  logic [63:0]       mem_dout,
    input  logic              mem_dout_ready
);

    state_t  state;
    logic    fifo_full;
    logic    fifo_empty;
    logic    push;
    logic    pop;
    wentry_t push_entry;
    wentry_t head;
    logic    rd_block_q;
    logic    rd_start;
    logic    cache_hit;
    logic [63:0] cache_data;

    assign mem_burstcnt = BURST_ONE;

    assign push       = ddram_we && !fifo_full;
    assign push_entry = '{addr: ddram_addr, be: ddram_be, din: ddram_din};
    // WR_ISSUE is only entered with a non-empty FIFO; pop on command accept.
    assign pop        = (state == WR_ISSUE) && !mem_busy;

    // The requester keeps rd high through the dout_ready cycle and one more;
    // block a new read start across both so the same read is not re-issued.
    // A same-cycle write wins: it shares ddram_addr and must land first.
    assign rd_start = ddram_rd && fifo_empty && !ddram_we &&
                      !ddram_dout_ready && !rd_block_q;

    pgm_ddram_wfifo #(.DEPTH(WFIFO_DEPTH)) u_wfifo (
        .fixed_50m_clk (fixed_50m_clk),
        .reset_n       (reset_n),
        .push          (push),
        .push_data     (push_entry),
        .pop           (pop),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .head          (head)
    );

`ifdef PGM_DDRAM_RDCACHE_EN
    logic              c_valid;
    logic [ADDR_W-1:0] c_tag;
    logic [63:0]       c_data;
    // Set when a write to the in-flight read address is buffered during the
    // read: the returning DDR data is already stale, so it must not be cached.
    logic              c_stale;
    logic              push_hits_rd;

    assign cache_hit    = c_valid && (c_tag == ddram_addr);
    assign cache_data   = c_data;
    assign push_hits_rd = push && (ddram_addr == mem_addr) &&
                          ((state == RD_ISSUE) || (state == RD_WAIT));

    always_ff @(posedge fixed_50m_clk or negedge reset_n) begin
        if (!reset_n) begin
            c_valid <= 1'b0;
            c_tag   <= '0;
            c_data  <= '0;
            c_stale <= 1'b0;
        end else begin
            if (push && c_valid && (ddram_addr == c_tag))
                c_valid <= 1'b0;
            if (push_hits_rd)
                c_stale <= 1'b1;
            // Fill last so it overrides the invalidate above; its own validity
            // already accounts for a same-cycle conflicting push.
            if ((state == RD_WAIT) && mem_dout_ready) begin
                c_tag   <= mem_addr;
                c_data  <= mem_dout;
                c_valid <= !(c_stale || push_hits_rd);
                c_stale <= 1'b0;
            end
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    always_ff @(posedge fixed_50m_clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            mem_rd           <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_din          <= '0;
            mem_be           <= '0;
            ddram_dout       <= '0;
            ddram_dout_ready <= 1'b0;
            ddram_busy       <= 1'b0;
            rd_block_q       <= 1'b0;
        end else begin
            ddram_busy       <= fifo_full || (state != IDLE) || (ddram_rd && !fifo_empty);
            ddram_dout_ready <= (state == RD_DONE);
            rd_block_q       <= ddram_dout_ready;

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state    <= WR_ISSUE;
                        mem_we   <= 1'b1;
                        mem_addr <= head.addr;
                        mem_be   <= head.be;
                        mem_din  <= head.din;
                    end else if (rd_start) begin
                        if (cache_hit) begin
                            ddram_dout <= cache_data;
                            state      <= RD_DONE;
                        end else begin
                            mem_rd   <= 1'b1;
                            mem_addr <= ddram_addr;
                            state    <= RD_ISSUE;
                        end
                    end
                end
                WR_ISSUE: begin
                    if (!mem_busy) begin
                        mem_we <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    if (!mem_busy) begin
                        mem_rd <= 1'b0;
                        state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_dout_ready) begin
                        ddram_dout <= mem_dout;
                        state      <= RD_DONE;
                    end
                end
                RD_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
